dp_op_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared operand/code datapath (33-bit `a`/`b` operands, 3-bit code select, 8-bit code result). It accepts operation requests from two requesters with valid/ready handshakes and grants them round-robin. For the granted request it drives registered operands and select to the datapath, then waits a fixed latency and captures the 8-bit code. The result is returned on a held response channel, guarded by a watchdog.

---
 rtl/dp_op_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_dp_op_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dp_op_arbiter.sv
// dp_op_arbiter
// Two-requester round-robin front end for the shared operand/code datapath.
// One operation is in flight at a time: the granted request's operands are
// registered onto dp_*, the code is captured a fixed number of cycles later,
// and the result is held on rsp_* until consumed or dropped by the watchdog.
module dp_op_arbiter #(
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned DP_LATENCY = 1,
  parameter logic [7:0]  DOG_LIMIT  = 8'hAC
) (
  input  logic                 sysclk,
  input  logic                 reset,
  // requester 0
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [BUS_WIDTH:0]   req0_a,
  input  logic [BUS_WIDTH:0]   req0_b,
  input  logic [2:0]           req0_sel,
  // requester 1
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [BUS_WIDTH:0]   req1_a,
  input  logic [BUS_WIDTH:0]   req1_b,
  input  logic [2:0]           req1_sel,
  // datapath
  output logic [BUS_WIDTH:0]   dp_a,
  output logic [BUS_WIDTH:0]   dp_b,
  output logic [2:0]           dp_sel,
  input  logic [7:0]           dp_code,
  // response
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [7:0]           rsp_code,
  output logic                 rsp_timeout,
  output logic [7:0]           timeout_count,
  output logic                 busy
);

  // Latency counter only needs to hold DP_LATENCY-1.
  localparam int unsigned     CW       = (DP_LATENCY > 1) ? $clog2(DP_LATENCY) : 1;
  localparam logic [CW-1:0]   LAT_LOAD = CW'(DP_LATENCY - 1);
  localparam logic [CW-1:0]   LAT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic [BUS_WIDTH:0] a;
    logic [BUS_WIDTH:0] b;
    logic [2:0]         sel;
  } op_t;

  state_t          r_state, w_next;
  op_t [1:0]       w_req;
  logic [1:0]      w_vld;
  logic            w_gnt_any, w_gnt_id, w_idle;
  logic            w_accept, w_capture, w_hs, w_expire, w_dog_hit;

  op_t             r_op;
  logic            r_rsp_id;
  logic            r_last_grant;
  logic [CW-1:0]   r_lat_cnt;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_code;
  logic [7:0]      r_dog;
  logic            r_timeout;
  logic [7:0]      r_to_cnt;
  logic            r_busy;

  assign w_req[0] = {req0_a, req0_b, req0_sel};
  assign w_req[1] = {req1_a, req1_b, req1_sel};
  assign w_vld    = {req1_valid, req0_valid};

  // Round-robin pick: a lone requester wins outright; on contention the one
  // not granted last time wins.
  always_comb begin
    w_gnt_any = |w_vld;
    w_gnt_id  = (&w_vld) ? ~r_last_grant : w_vld[1];
  end

  assign w_idle     = (r_state == S_IDLE);
  assign req0_ready = w_idle & w_gnt_any & ~w_gnt_id;
  assign req1_ready = w_idle & w_gnt_any &  w_gnt_id;

  // Expiry fires on the edge the counter would reach the limit, so rsp_valid
  // drops exactly DOG_LIMIT cycles after it rose. A limit of 0 never fires.
  assign w_dog_hit = (DOG_LIMIT != 8'd0) && ((r_dog + 8'd1) == DOG_LIMIT);

  // Sequencer state register.
  always_ff @(posedge sysclk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next state plus one-hot event strobes that steer the data registers.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_capture = 1'b0;
    w_hs      = 1'b0;
    w_expire  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_any) begin
          w_accept = 1'b1;
          w_next   = S_WAIT;
        end
      end
      S_WAIT: begin
        if (r_lat_cnt == '0) begin
          w_capture = 1'b1;
          w_next    = S_RESP;
        end
      end
      S_RESP: begin
        // A handshake on the expiry cycle takes priority over the drop.
        if (rsp_ready) begin
          w_hs   = 1'b1;
          w_next = S_IDLE;
        end else if (w_dog_hit) begin
          w_expire = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand/select latch and arbitration history; dp_* holds until next accept.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_op         <= '0;
      r_rsp_id     <= 1'b0;
      r_last_grant <= 1'b1;
    end else if (w_accept) begin
      r_op         <= w_req[w_gnt_id];
      r_rsp_id     <= w_gnt_id;
      r_last_grant <= w_gnt_id;
    end
  end

  // Datapath latency countdown, loaded on accept.
  always_ff @(posedge sysclk) begin
    if (!reset)                                     r_lat_cnt <= '0;
    else if (w_accept)                              r_lat_cnt <= LAT_LOAD;
    else if (r_state == S_WAIT && r_lat_cnt != '0)  r_lat_cnt <= r_lat_cnt - LAT_ONE;
  end

  // Response holding register: set on capture, cleared on handshake or drop.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_rsp_valid <= 1'b0;
      r_rsp_code  <= 8'd0;
    end else if (w_capture) begin
      r_rsp_valid <= 1'b1;
      r_rsp_code  <= dp_code;
    end else if (w_hs || w_expire) begin
      r_rsp_valid <= 1'b0;
    end
  end

  // Watchdog: counts cycles the held response goes unaccepted.
  always_ff @(posedge sysclk) begin
    if (!reset)
      r_dog <= 8'd0;
    else if (w_capture)
      r_dog <= 8'd0;
    else if (r_state == S_RESP && !rsp_ready && DOG_LIMIT != 8'd0)
      r_dog <= r_dog + 8'd1;
  end

  // Drop pulse and saturating drop counter.
  always_ff @(posedge sysclk) begin
    if (!reset) begin
      r_timeout <= 1'b0;
      r_to_cnt  <= 8'd0;
    end else begin
      r_timeout <= w_expire;
      if (w_expire && r_to_cnt != 8'hFF) r_to_cnt <= r_to_cnt + 8'd1;
    end
  end

  // Registered busy tracks the state the FSM is entering.
  always_ff @(posedge sysclk) begin
    if (!reset) r_busy <= 1'b0;
    else        r_busy <= (w_next != S_IDLE);
  end

  assign dp_a          = r_op.a;
  assign dp_b          = r_op.b;
  assign dp_sel        = r_op.sel;
  assign rsp_valid     = r_rsp_valid;
  assign rsp_id        = r_rsp_id;
  assign rsp_code      = r_rsp_code;
  assign rsp_timeout   = r_timeout;
  assign timeout_count = r_to_cnt;
  assign busy          = r_busy;

endmodule

// File: tb/tb_dp_op_arbiter.sv
// tb_dp_op_arbiter
// Two instances share stimulus: A (latency 1, watchdog 4) and B (latency 3,
// default watchdog). A timestamp-based transaction model predicts each
// instance every cycle; directed sequences add explicit constant checks.
module tb_dp_op_arbiter;
  localparam int LAT_A = 1;
  localparam int DOG_A = 4;
  localparam int LAT_B = 3;
  localparam int DOG_B = 8'hAC;

  logic        sysclk;
  logic        reset;
  logic        req0_valid, req1_valid, rsp_ready;
  logic [32:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_sel, req1_sel;

  logic [1:0]  rdy0, rdy1, rv, rid, rto, bsy;
  logic [32:0] dpa [2];
  logic [32:0] dpb [2];
  logic [2:0]  dps [2];
  logic [7:0]  dpc [2];
  logic [7:0]  rcode [2];
  logic [7:0]  tocnt [2];

  logic        ovr_en;
  logic [7:0]  ovr_val;

  int n_cmp = 0;
  int n_fail = 0;
  int ecyc = 0;

  // Downstream datapath behaviour.
  function automatic logic [7:0] dp_fn(input logic [32:0] a, input logic [32:0] b,
                                       input logic [2:0] s);
    logic [32:0] sum;
    logic [7:0]  r;
    sum = a + b + 33'd1;
    case (s)
      3'b000, 3'b110: r = 8'hC0;
      3'b101:         r = 8'hE2;
      3'b010:         r = 8'hFF;
      3'b011:         r = 8'h00;
      default:        r = sum[7:0];
    endcase
    return r;
  endfunction

  assign dpc[0] = dp_fn(dpa[0], dpb[0], dps[0]);
  assign dpc[1] = ovr_en ? ovr_val : dp_fn(dpa[1], dpb[1], dps[1]);

  dp_op_arbiter #(.BUS_WIDTH(32), .DP_LATENCY(LAT_A), .DOG_LIMIT(8'(DOG_A))) u_a (
    .sysclk(sysclk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rdy0[0]), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(rdy1[0]), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .dp_a(dpa[0]), .dp_b(dpb[0]), .dp_sel(dps[0]), .dp_code(dpc[0]),
    .rsp_valid(rv[0]), .rsp_ready(rsp_ready), .rsp_id(rid[0]), .rsp_code(rcode[0]),
    .rsp_timeout(rto[0]), .timeout_count(tocnt[0]), .busy(bsy[0]));

  dp_op_arbiter #(.BUS_WIDTH(32), .DP_LATENCY(LAT_B), .DOG_LIMIT(8'(DOG_B))) u_b (
    .sysclk(sysclk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(rdy0[1]), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(rdy1[1]), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .dp_a(dpa[1]), .dp_b(dpb[1]), .dp_sel(dps[1]), .dp_code(dpc[1]),
    .rsp_valid(rv[1]), .rsp_ready(rsp_ready), .rsp_id(rid[1]), .rsp_code(rcode[1]),
    .rsp_timeout(rto[1]), .timeout_count(tocnt[1]), .busy(bsy[1]));

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, want finish before 200000");
    $fatal(1);
  end

  // Transaction model: an op is described by its accept cycle and the cycle
  // its response rose; everything else follows from those timestamps.
  bit          m_have [2];
  bit          m_rv   [2];
  bit          m_id   [2];
  bit          m_last [2];
  bit          m_to   [2];
  int          m_acc  [2];
  int          m_rise [2];
  logic [32:0] m_a    [2];
  logic [32:0] m_b    [2];
  logic [2:0]  m_sel  [2];
  logic [7:0]  m_code [2];
  logic [7:0]  m_tocnt[2];

  function automatic int exp_grant(input int d);
    if (m_have[d]) return -1;
    if (req0_valid && req1_valid) return m_last[d] ? 0 : 1;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic model_step(input int d);
    int lat, dog, g;
    logic [7:0] cnow;
    lat  = (d == 0) ? LAT_A : LAT_B;
    dog  = (d == 0) ? DOG_A : DOG_B;
    cnow = (d == 1 && ovr_en) ? ovr_val : dp_fn(m_a[d], m_b[d], m_sel[d]);
    g    = exp_grant(d);
    m_to[d] = 1'b0;
    if (!reset) begin
      m_have[d] = 0; m_rv[d] = 0; m_id[d] = 0; m_last[d] = 1;
      m_a[d] = '0; m_b[d] = '0; m_sel[d] = '0; m_code[d] = '0; m_tocnt[d] = '0;
    end else if (!m_have[d]) begin
      if (g >= 0) begin
        m_have[d] = 1; m_acc[d] = ecyc; m_id[d] = g[0]; m_last[d] = g[0];
        m_a[d]   = g[0] ? req1_a   : req0_a;
        m_b[d]   = g[0] ? req1_b   : req0_b;
        m_sel[d] = g[0] ? req1_sel : req0_sel;
      end
    end else if (!m_rv[d]) begin
      if (ecyc - m_acc[d] == lat) begin
        m_rv[d] = 1; m_rise[d] = ecyc; m_code[d] = cnow;
      end
    end else begin
      if (rsp_ready) begin
        m_rv[d] = 0; m_have[d] = 0;
      end else if (dog != 0 && ecyc - m_rise[d] == dog) begin
        m_rv[d] = 0; m_have[d] = 0; m_to[d] = 1;
        if (m_tocnt[d] != 8'hFF) m_tocnt[d] = m_tocnt[d] + 8'd1;
      end
    end
  endtask

  task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h want %0h (cycle %0d)", nm, d, act, exp, ecyc);
    end
  endtask

  task automatic compare_pre(input int d);
    int g;
    g = exp_grant(d);
    chk("req0_ready", d, 64'(rdy0[d]), 64'(g == 0));
    chk("req1_ready", d, 64'(rdy1[d]), 64'(g == 1));
  endtask

  task automatic compare_post(input int d);
    chk("dp_a",          d, 64'(dpa[d]),   64'(m_a[d]));
    chk("dp_b",          d, 64'(dpb[d]),   64'(m_b[d]));
    chk("dp_sel",        d, 64'(dps[d]),   64'(m_sel[d]));
    chk("rsp_valid",     d, 64'(rv[d]),    64'(m_rv[d]));
    chk("rsp_id",        d, 64'(rid[d]),   64'(m_id[d]));
    chk("rsp_code",      d, 64'(rcode[d]), 64'(m_code[d]));
    chk("rsp_timeout",   d, 64'(rto[d]),   64'(m_to[d]));
    chk("timeout_count", d, 64'(tocnt[d]), 64'(m_tocnt[d]));
    chk("busy",          d, 64'(bsy[d]),   64'(m_have[d]));
  endtask

  // Called at a negedge with inputs already driven.
  task automatic step(input bit do_pre);
    #1;
    if (do_pre) begin compare_pre(0); compare_pre(1); end
    @(posedge sysclk);
    ecyc++;
    model_step(0);
    model_step(1);
    @(negedge sysclk);
    compare_post(0);
    compare_post(1);
  endtask

  task automatic set_req0(input bit v, input logic [32:0] a, input logic [32:0] b, input logic [2:0] s);
    req0_valid = v; req0_a = a; req0_b = b; req0_sel = s;
  endtask

  task automatic set_req1(input bit v, input logic [32:0] a, input logic [32:0] b, input logic [2:0] s);
    req1_valid = v; req1_a = a; req1_b = b; req1_sel = s;
  endtask

  task automatic drain();
    req0_valid = 0; req1_valid = 0; rsp_ready = 1;
    for (int i = 0; i < 6; i++) step(1);
  endtask

  typedef struct {
    logic [32:0] a;
    logic [32:0] b;
    logic [2:0]  sel;
    logic [7:0]  code;
  } vec_t;

  vec_t tbl [8];
  int   gid [4];
  int   gcy [4];

  initial begin
    int ng, hi;
    bit fell;

    tbl[0] = '{33'd0,   33'd0, 3'b000, 8'hC0};
    tbl[1] = '{33'd0,   33'd0, 3'b101, 8'hE2};
    tbl[2] = '{33'd0,   33'd0, 3'b010, 8'hFF};
    tbl[3] = '{33'd0,   33'd0, 3'b011, 8'h00};
    tbl[4] = '{33'd255, 33'd0, 3'b111, 8'h00};
    tbl[5] = '{33'd5,   33'd7, 3'b100, 8'h0D};
    tbl[6] = '{33'h1_FFFF_FFFF, 33'd2, 3'b001, 8'h02};
    tbl[7] = '{33'd9,   33'd9, 3'b110, 8'hC0};

    reset = 0; rsp_ready = 0; ovr_en = 0; ovr_val = 0;
    set_req0(0, 0, 0, 0);
    set_req1(0, 0, 0, 0);
    @(negedge sysclk);
    step(0);
    step(0);
    chk("reset_busy", 0, 64'(bsy[0]), 64'd0);
    chk("reset_rsp_valid", 0, 64'(rv[0]), 64'd0);
    reset = 1;

    // Single op: 5+7+1 on requester 0.
    set_req0(1, 33'd5, 33'd7, 3'b100);
    #1 chk("t1_ready", 0, 64'(rdy0[0]), 64'd1);
    step(1);
    req0_valid = 0;
    chk("t1_no_rsp_yet", 0, 64'(rv[0]), 64'd0);
    step(1);
    chk("t1_rsp_valid", 0, 64'(rv[0]), 64'd1);
    chk("t1_rsp_code", 0, 64'(rcode[0]), 64'h0D);
    chk("t1_rsp_id", 0, 64'(rid[0]), 64'd0);
    drain();

    // Round robin under continuous contention.
    reset = 0; step(1); reset = 1;
    set_req0(1, 33'd1, 33'd2, 3'b100);
    set_req1(1, 33'd3, 33'd4, 3'b100);
    rsp_ready = 1;
    ng = 0;
    for (int i = 0; i < 30 && ng < 4; i++) begin
      #1;
      if (rdy0[0] || rdy1[0]) begin gid[ng] = int'(rdy1[0]); gcy[ng] = ecyc; ng++; end
      step(1);
    end
    chk("rr_count", 0, 64'(ng), 64'd4);
    for (int k = 0; k < 4; k++) chk("rr_order", 0, 64'(gid[k]), 64'(k % 2));
    for (int k = 1; k < 4; k++) chk("rr_gap", 0, 64'(gcy[k] - gcy[k-1]), 64'd3);
    drain();

    // Select sweep with held response.
    for (int t = 0; t < 8; t++) begin
      rsp_ready = 0;
      set_req0(1, tbl[t].a, tbl[t].b, tbl[t].sel);
      step(1);
      req0_valid = 0;
      step(1);
      chk("tbl_valid", 0, 64'(rv[0]), 64'd1);
      chk("tbl_code", 0, 64'(rcode[0]), 64'(tbl[t].code));
      chk("tbl_dp_sel", 0, 64'(dps[0]), 64'(tbl[t].sel));
      for (int s = 0; s < 2; s++) begin
        step(1);
        chk("tbl_code_hold", 0, 64'(rcode[0]), 64'(tbl[t].code));
      end
      rsp_ready = 1;
      step(1);
      chk("tbl_released", 0, 64'(rv[0]), 64'd0);
    end
    drain();

    // Watchdog expiry on A, then handshake on the expiry cycle.
    rsp_ready = 0;
    set_req0(1, 33'd1, 33'd1, 3'b100);
    step(1);
    hi = 0; fell = 0;
    for (int i = 0; i < 12 && !fell; i++) begin
      step(1);
      if (rv[0]) hi++;
      else if (hi > 0) fell = 1;
    end
    chk("dog_fell", 0, 64'(fell), 64'd1);
    chk("dog_hi_cycles", 0, 64'(hi), 64'd4);
    chk("dog_pulse", 0, 64'(rto[0]), 64'd1);
    chk("dog_count", 0, 64'(tocnt[0]), 64'd1);
    #1 chk("dog_next_accept", 0, 64'(rdy0[0]), 64'd1);
    step(1);
    req0_valid = 0;
    step(1);
    chk("dog_pulse_end", 0, 64'(rto[0]), 64'd0);
    chk("dog_rsp2", 0, 64'(rv[0]), 64'd1);
    for (int i = 0; i < 3; i++) step(1);
    rsp_ready = 1;
    step(1);
    chk("dog_hs_wins_valid", 0, 64'(rv[0]), 64'd0);
    chk("dog_hs_wins_pulse", 0, 64'(rto[0]), 64'd0);
    chk("dog_hs_wins_count", 0, 64'(tocnt[0]), 64'd1);
    drain();

    // Reset during WAIT on B; afterwards req0 preferred.
    set_req1(1, 33'd7, 33'd8, 3'b100);
    step(1);
    reset = 0;
    step(1);
    chk("rst_rsp_valid", 1, 64'(rv[1]), 64'd0);
    chk("rst_busy", 1, 64'(bsy[1]), 64'd0);
    chk("rst_dp_a", 1, 64'(dpa[1]), 64'd0);
    chk("rst_rsp_id", 1, 64'(rid[1]), 64'd0);
    chk("rst_count_a", 0, 64'(tocnt[0]), 64'd0);
    reset = 1;
    set_req0(1, 33'd2, 33'd3, 3'b100);
    #1;
    chk("rst_pref_r0", 1, 64'(rdy0[1]), 64'd1);
    chk("rst_pref_r1", 1, 64'(rdy1[1]), 64'd0);
    step(1);
    req0_valid = 0; req1_valid = 0;
    hi = 0;
    for (int i = 0; i < 6 && !rv[1]; i++) begin step(1); hi++; end
    chk("rst_new_lat", 1, 64'(hi), 64'd3);
    chk("rst_new_id", 1, 64'(rid[1]), 64'd0);
    drain();

    // Latency 3 captures the code present on the capture cycle only.
    ovr_en = 1; ovr_val = 8'h11; rsp_ready = 0;
    set_req1(1, 33'd4, 33'd4, 3'b100);
    step(1);
    req1_valid = 0;
    ovr_val = 8'h22; step(1);
    chk("lat3_early1", 1, 64'(rv[1]), 64'd0);
    ovr_val = 8'h33; step(1);
    chk("lat3_early2", 1, 64'(rv[1]), 64'd0);
    ovr_val = 8'h5A; step(1);
    chk("lat3_valid", 1, 64'(rv[1]), 64'd1);
    chk("lat3_code", 1, 64'(rcode[1]), 64'h5A);
    ovr_val = 8'h77; step(1);
    chk("lat3_hold", 1, 64'(rcode[1]), 64'h5A);
    ovr_en = 0;
    drain();

    // Randomised traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset      = ($urandom_range(0, 99) >= 2);
      rsp_ready  = ($urandom_range(0, 99) < 70);
      ovr_en     = ($urandom_range(0, 99) < 20);
      ovr_val    = 8'($urandom);
      set_req0($urandom_range(0, 99) < 60, {1'($urandom_range(0, 1)), 32'($urandom)},
               {1'($urandom_range(0, 1)), 32'($urandom)}, 3'($urandom));
      set_req1($urandom_range(0, 99) < 60, {1'($urandom_range(0, 1)), 32'($urandom)},
               {1'($urandom_range(0, 1)), 32'($urandom)}, 3'($urandom));
      step(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
